// File: rtl/idma_axis_read_sub.sv
// iDMA AXI Stream read task: receives stream beats into a 2-deep FIFO, then masks,
// rotates and atomically pushes them into the per-lane dataflow buffer.
module idma_axis_read_sub #(
    parameter int unsigned StrbWidth    = 16,
    parameter int unsigned BeatCntWidth = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 r_dp_req_valid_i,
    output logic                                 r_dp_req_ready_o,
    input  logic [$clog2(StrbWidth)-1:0]         r_dp_offset_i,
    input  logic [$clog2(StrbWidth)-1:0]         r_dp_tailer_i,
    input  logic [$clog2(StrbWidth)-1:0]         r_dp_shift_i,
    input  logic [BeatCntWidth-1:0]              r_dp_num_beats_i,
    output logic                                 r_dp_rsp_valid_o,
    input  logic                                 r_dp_rsp_ready_i,
    output logic                                 r_dp_rsp_err_o,
    input  logic                                 dp_poison_i,
    input  logic [8*StrbWidth-1:0]               t_data_i,
    input  logic                                 t_last_i,
    input  logic                                 t_valid_i,
    output logic                                 t_ready_o,
    output logic [8*StrbWidth-1:0]               buffer_in_o,
    output logic [StrbWidth-1:0]                 buffer_in_valid_o,
    input  logic [StrbWidth-1:0]                 buffer_in_ready_i
);
    localparam int unsigned OffW  = $clog2(StrbWidth);
    localparam int unsigned DataW = 8 * StrbWidth;
    localparam logic [StrbWidth-1:0] Ones = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                  state_q;
    logic [DataW-1:0]        fifo_data_q [2];
    logic [1:0]              fifo_last_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;
    logic [OffW-1:0]         offset_q;
    logic [OffW-1:0]         tailer_q;
    logic [OffW-1:0]         shift_q;
    logic [BeatCntWidth-1:0] cnt_q;
    logic                    first_q;
    logic                    err_q;

    logic                    fill;
    logic                    pop;
    logic                    active_head;
    logic                    is_last;
    logic                    fit;
    logic [DataW-1:0]        head_data;
    logic                    head_last;
    logic [OffW:0]           tail_sh;
    logic [StrbWidth-1:0]    mask;
    logic [2*StrbWidth-1:0]  rot2;
    logic [StrbWidth-1:0]    rmask;
    logic [OffW-1:0]         src;

    assign t_ready_o        = (count_q != 2'd2);
    assign r_dp_req_ready_o = (state_q == IDLE);
    assign r_dp_rsp_valid_o = (state_q == RESP);
    assign r_dp_rsp_err_o   = (state_q == RESP) & err_q;

    assign fill        = t_valid_i & t_ready_o;
    assign head_data   = fifo_data_q[rd_ptr_q];
    assign head_last   = fifo_last_q[rd_ptr_q];
    assign active_head = (state_q == ACTIVE) && (count_q != 2'd0);
    assign is_last     = (cnt_q == '0);
    assign tail_sh     = (OffW+1)'(StrbWidth) - (OffW+1)'(tailer_q);

    // Lane mask for the head beat, rotated into buffer lane order alongside its data.
    always_comb begin
        mask = Ones;
        if (first_q) mask = mask & (Ones << offset_q);
        if (is_last && (tailer_q != '0)) mask = mask & (Ones >> tail_sh);
        rot2  = {mask, mask} << shift_q;
        rmask = rot2[2*StrbWidth-1 -: StrbWidth];
        buffer_in_o = '0;
        src         = '0;
        for (int i = 0; i < int'(StrbWidth); i++) begin
            src = OffW'(i) - shift_q;
            if (rmask[i]) buffer_in_o[i*8 +: 8] = head_data[{src, 3'b000} +: 8];
        end
    end

    // Push only when every lane of the beat can be accepted at once.
    assign fit               = ((buffer_in_ready_i & rmask) == rmask);
    assign pop               = active_head && (dp_poison_i || fit);
    assign buffer_in_valid_o = (active_head && !dp_poison_i && fit) ? rmask : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            if (fill) begin
                fifo_data_q[wr_ptr_q] <= t_data_i;
                fifo_last_q[wr_ptr_q] <= t_last_i;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(fill) - 2'(pop);
        end
    end

    // Transfer control: latch request, count beats, report tlast mismatches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            offset_q <= '0;
            tailer_q <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r_dp_req_valid_i) begin
                        offset_q <= r_dp_offset_i;
                        tailer_q <= r_dp_tailer_i;
                        shift_q  <= r_dp_shift_i;
                        cnt_q    <= r_dp_num_beats_i;
                        first_q  <= 1'b1;
                        err_q    <= 1'b0;
                        state_q  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pop) begin
                        first_q <= 1'b0;
                        if (head_last != is_last) err_q <= 1'b1;
                        if (is_last) state_q <= RESP;
                        else         cnt_q   <= cnt_q - BeatCntWidth'(1);
                    end
                end
                RESP: begin
                    if (r_dp_rsp_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
